// File: rtl/accumulator_bank_if.sv
// Stream/dump/result handshake bundle for accumulator_bank.
// master = sample source / result consumer side, slave = the accumulator bank.
interface accumulator_bank_if #(
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 24,
  parameter int CHANNELS  = 4,
  parameter int CH_W      = $clog2(CHANNELS)
);
  logic                 in_valid;
  logic                 in_ready;
  logic [IN_WIDTH-1:0]  in_data;
  logic [CH_W-1:0]      in_chan;
  logic                 dump_valid;
  logic                 dump_ready;
  logic [CH_W-1:0]      dump_chan;
  logic                 clear_all;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_data;
  logic [CH_W-1:0]      out_chan;
  logic                 out_ovf;
  logic                 busy;

  modport master (
    output in_valid, in_data, in_chan, dump_valid, dump_chan, clear_all, out_ready,
    input  in_ready, dump_ready, out_valid, out_data, out_chan, out_ovf, busy
  );
  modport slave (
    input  in_valid, in_data, in_chan, dump_valid, dump_chan, clear_all, out_ready,
    output in_ready, dump_ready, out_valid, out_data, out_chan, out_ovf, busy
  );
endinterface

// File: rtl/accumulator_bank.sv
// N-channel accumulator bank with read-and-clear dump, clear-all sweep and sticky overflow.
// Define ACC_SATURATE_EN to clamp on overflow instead of wrapping.
module acc_lane #(
  parameter int ACC_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 add_en,
  input  logic [ACC_WIDTH-1:0] add_val,
  input  logic                 clr,
  output logic [ACC_WIDTH-1:0] acc_q,
  output logic                 ovf_q
);
  logic [ACC_WIDTH:0]   sum;
  logic [ACC_WIDTH-1:0] acc_d;
  logic                 ovf_d;

  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, add_val};
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (clr) begin
      // a colliding sample lands on the freshly cleared register, so it cannot overflow
      acc_d = add_en ? add_val : '0;
      ovf_d = 1'b0;
    end else if (add_en) begin
      ovf_d = ovf_q | sum[ACC_WIDTH];
`ifdef ACC_SATURATE_EN
      acc_d = sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
`else
      acc_d = sum[ACC_WIDTH-1:0];
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end
endmodule

module accumulator_bank #(
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 24,
  parameter int CHANNELS  = 4,
  parameter int CH_W      = $clog2(CHANNELS)
) (
  input  logic             clk,
  input  logic             reset,
  accumulator_bank_if.slave bus
);
  typedef enum logic {IDLE, SWEEP} state_t;

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

  state_t                               state_q;
  logic [CH_W-1:0]                      cnt_q;
  logic                                 busy_q;
  logic [CHANNELS-1:0][ACC_WIDTH-1:0]   acc;
  logic [CHANNELS-1:0]                  ovf;
  logic                                 in_fire, dump_rdy, dump_fire;
  logic                                 out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0]                 out_data_q, out_data_d;
  logic [CH_W-1:0]                      out_chan_q, out_chan_d;
  logic                                 out_ovf_q, out_ovf_d;

  assign in_fire   = bus.in_valid && !busy_q;
  assign dump_rdy  = !busy_q && (!out_valid_q || bus.out_ready);
  assign dump_fire = bus.dump_valid && dump_rdy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.clear_all) begin
          state_q <= SWEEP;
          busy_q  <= 1'b1;
          cnt_q   <= '0;
        end
        SWEEP: if (cnt_q == LAST_CH) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    acc_lane #(.ACC_WIDTH(ACC_WIDTH)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .add_en (in_fire && bus.in_chan == CH_W'(i)),
      .add_val(ACC_WIDTH'(bus.in_data)),
      .clr    ((dump_fire && bus.dump_chan == CH_W'(i)) || (busy_q && cnt_q == CH_W'(i))),
      .acc_q  (acc[i]),
      .ovf_q  (ovf[i])
    );
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_ovf_d   = out_ovf_q;
    if (dump_fire) begin
      out_valid_d = 1'b1;
      out_data_d  = acc[bus.dump_chan];
      out_chan_d  = bus.dump_chan;
      out_ovf_d   = ovf[bus.dump_chan];
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign bus.in_ready   = !busy_q;
  assign bus.dump_ready = dump_rdy;
  assign bus.busy       = busy_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_chan   = out_chan_q;
  assign bus.out_ovf    = out_ovf_q;
endmodule

// File: tb/tb_accumulator_bank.sv
// Randomized + directed bench for accumulator_bank: reference model feeds a result
// scoreboard that an independent output monitor drains.
module tb_accumulator_bank;
  localparam int IW = 16;
  localparam int AW = 24;
  localparam int CH = 4;
  localparam int CW = $clog2(CH);
  localparam longint MAXV = (longint'(1) << AW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  accumulator_bank_if #(.IN_WIDTH(IW), .ACC_WIDTH(AW), .CHANNELS(CH)) bus ();
  accumulator_bank #(.IN_WIDTH(IW), .ACC_WIDTH(AW), .CHANNELS(CH)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {longint data; bit ovf; int ch;} res_t;
  res_t   sb[$];
  longint m_acc[CH];
  bit     m_ovf[CH];
  int     sweep_left;
  bit     pending;
  int     checks = 0;
  int     errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_acc[i] = 0;
      m_ovf[i] = 1'b0;
    end
    sweep_left = 0;
    pending    = 1'b0;
    sb.delete();
  endtask

  task automatic drive(input bit iv, input int id, input int ic, input bit dv,
                       input int dc, input bit ca, input bit ordy);
    bus.in_valid   = iv;
    bus.in_data    = IW'(id);
    bus.in_chan    = CW'(ic);
    bus.dump_valid = dv;
    bus.dump_chan  = CW'(dc);
    bus.clear_all  = ca;
    bus.out_ready  = ordy;
  endtask

  // One clock of stimulus; the model then advances as the coming edge will.
  task automatic cycle(input bit iv, input int id, input int ic, input bit dv,
                       input int dc, input bit ca, input bit ordy);
    bit exp_ir, exp_dr;
    longint s;
    @(negedge clk);
    drive(iv, id, ic, dv, dc, ca, ordy);
    #1;
    exp_ir = (sweep_left == 0);
    exp_dr = exp_ir && (!pending || ordy);
    chk("in_ready", 64'(bus.in_ready), 64'(exp_ir));
    chk("dump_ready", 64'(bus.dump_ready), 64'(exp_dr));
    chk("busy", 64'(bus.busy), 64'(!exp_ir));
    if (pending && ordy) pending = 1'b0;
    if (sweep_left > 0) begin
      m_acc[CH - sweep_left] = 0;
      m_ovf[CH - sweep_left] = 1'b0;
      sweep_left--;
    end else begin
      if (dv && exp_dr) begin
        sb.push_back('{m_acc[dc], m_ovf[dc], dc});
        m_acc[dc] = 0;
        m_ovf[dc] = 1'b0;
        pending   = 1'b1;
      end
      if (iv) begin
        s = m_acc[ic] + longint'(bus.in_data);
        if (s > MAXV) begin
          m_ovf[ic] = 1'b1;
`ifdef ACC_SATURATE_EN
          s = MAXV;
`else
          s = s - (MAXV + 1);
`endif
        end
        m_acc[ic] = s;
      end
      if (ca) sweep_left = CH;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic dump(input int c);
    cycle(0, 0, 0, 1, c, 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    model_reset();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_out_chan", 64'(bus.out_chan), 64'd0);
    chk("rst_out_ovf", 64'(bus.out_ovf), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_dump_ready", 64'(bus.dump_ready), 64'd1);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Output monitor: the held result must match the oldest expected one; pop on handshake.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (reset && bus.out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected: got out_valid=1 chan=%0d expected no pending result", bus.out_chan);
        end else begin
          chk("out_data", 64'(bus.out_data), 64'(sb[0].data));
          chk("out_ovf", 64'(bus.out_ovf), 64'(sb[0].ovf));
          chk("out_chan", 64'(bus.out_chan), 64'(sb[0].ch));
          if (bus.out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    do_reset();
    for (int c = 0; c < CH; c++) dump(c);
    idle(2);

    // multi-channel accumulate
    cycle(1, 100, 0, 0, 0, 0, 1);
    cycle(1, 200, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(1, 'hFFFF, 3, 0, 0, 0, 1);
    dump(0);
    dump(3);
    dump(0);
    idle(2);

    // same-channel collision
    cycle(1, 50, 1, 0, 0, 0, 1);
    cycle(1, 7, 1, 1, 1, 0, 1);
    dump(1);
    idle(2);

    // backpressure
    cycle(1, 9, 0, 1, 0, 0, 0);
    cycle(1, 11, 1, 1, 1, 0, 0);
    cycle(0, 0, 0, 1, 1, 0, 0);
    cycle(0, 0, 0, 1, 1, 0, 0);
    cycle(0, 0, 0, 1, 1, 0, 1);
    idle(2);

    // overflow on ch2: preload to 0xFFFFF0 then add 0x20
    dump(2);
    for (int i = 0; i < 256; i++) cycle(1, 'hFFFF, 2, 0, 0, 0, 1);
    cycle(1, 'hF0, 2, 0, 0, 0, 1);
    cycle(1, 'h20, 2, 0, 0, 0, 1);
    cycle(1, 'hFFFF, 2, 0, 0, 0, 1);
    dump(2);
    idle(2);

    // clear sweep: blocked samples during the sweep, zeros afterwards
    for (int c = 0; c < CH; c++) cycle(1, $urandom_range(1, 'hFFFF), c, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < CH; i++) cycle(1, $urandom_range(1, 'hFFFF), i, 1, i, 1, 1);
    for (int c = 0; c < CH; c++) dump(c);
    idle(2);

    // mid-sweep reset with a result pending
    for (int c = 0; c < CH; c++) cycle(1, $urandom_range(1, 'hFFFF), c, 0, 0, 0, 1);
    cycle(0, 0, 0, 1, 3, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    do_reset();
    for (int c = 0; c < CH; c++) dump(c);
    idle(2);

    // random traffic
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 'hFFFF)), int'($urandom_range(0, CH - 1)),
            $urandom_range(0, 1) == 1, int'($urandom_range(0, CH - 1)),
            $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0);
    idle(CH + 4);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d results left expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
